// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
// Owns the fetch PC, rides out icache misses with a RUN/MISS/DRAIN machine,
// absorbs decode stalls and execute redirects, and presents a registered
// instruction (with a valid flag) to decode.
// Optional feature macro: FETCH_PERF_EN adds perf_fetched / perf_miss_cycles.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_d,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            icache_req,
  output logic [XLEN-1:0] icache_addr,
  input  logic [31:0]     icache_rdata,
  input  logic            icache_hit,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d,
  output logic [6:0]      opcode_d,
  output logic [2:0]      funct_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_miss_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] PC_INC = {{(XLEN-3){1'b0}}, 3'b100};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pcplus4_q, id_pcplus4_d;
  logic            id_valid_q, id_valid_d;
  logic            fetch_load_s;

  logic [XLEN-1:0] redirect_tgt_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic            unused_redirect_lsb_s;

  // Redirect targets are word aligned; the low address bits are dropped.
  assign redirect_tgt_s        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb_s = ^redirect_pc[1:0];
  assign pc_plus4_s            = pc_f_q + PC_INC;

  // Next-state logic: redirect beats stall, stall beats normal fetch.
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    pend_pc_d    = pend_pc_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_pcplus4_d = id_pcplus4_q;
    id_valid_d   = id_valid_q;
    fetch_load_s = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_f_d     = redirect_tgt_s;
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
        end else if (stall_d) begin
          state_d = RUN;          // hold PC and IF/ID, re-issue same fetch
        end else if (icache_hit) begin
          id_instr_d   = icache_rdata;
          id_pc_d      = pc_f_q;
          id_pcplus4_d = pc_plus4_s;
          id_valid_d   = 1'b1;
          pc_f_d       = pc_plus4_s;
          fetch_load_s = 1'b1;
        end else begin
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
          state_d    = MISS;
        end
      end
      MISS: begin
        if (redirect_valid) begin
          // Let the outstanding refill finish before fetching the target.
          pend_pc_d  = redirect_tgt_s;
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
          state_d    = DRAIN;
        end else if (stall_d) begin
          state_d = MISS;         // hold IF/ID; a hit is re-presented later
        end else if (icache_hit) begin
          id_instr_d   = icache_rdata;
          id_pc_d      = pc_f_q;
          id_pcplus4_d = pc_plus4_s;
          id_valid_d   = 1'b1;
          pc_f_d       = pc_plus4_s;
          fetch_load_s = 1'b1;
          state_d      = RUN;
        end else begin
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pend_pc_d  = redirect_tgt_s;   // newest redirect wins
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
        end else if (stall_d) begin
          state_d = DRAIN;
        end else if (icache_hit) begin
          // Refill for the stale address is done; its word is dropped.
          pc_f_d     = pend_pc_q;
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
          state_d    = RUN;
        end else begin
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
        end
      end
      default: begin
        state_d    = RUN;
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
    endcase
  end

  // State, fetch PC and IF/ID register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      pc_f_q       <= RESET_PC;
      pend_pc_q    <= '0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= '0;
      id_pcplus4_q <= '0;
      id_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      pend_pc_q    <= pend_pc_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pcplus4_q <= id_pcplus4_d;
      id_valid_q   <= id_valid_d;
    end
  end

  assign icache_req  = reset;
  assign icache_addr = pc_f_q;
  assign instr_d     = id_instr_q;
  assign pc_d        = id_pc_q;
  assign pcplus4_d   = id_pcplus4_q;
  assign valid_d     = id_valid_q;
  assign opcode_d    = id_instr_q[6:0];
  assign funct_d     = id_instr_q[14:12];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_miss_cycles_q, perf_miss_cycles_d;

  // Counter updates: valid IF/ID loads and cycles spent off the RUN state.
  always_comb begin
    perf_fetched_d     = perf_fetched_q;
    perf_miss_cycles_d = perf_miss_cycles_q;
    if (fetch_load_s) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end else begin
      perf_fetched_d = perf_fetched_q;
    end
    if (state_q != RUN) begin
      perf_miss_cycles_d = perf_miss_cycles_q + 32'd1;
    end else begin
      perf_miss_cycles_d = perf_miss_cycles_q;
    end
  end

  // Performance counter registers, cleared by reset, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched_q     <= 32'd0;
      perf_miss_cycles_q <= 32'd0;
    end else begin
      perf_fetched_q     <= perf_fetched_d;
      perf_miss_cycles_q <= perf_miss_cycles_d;
    end
  end

  assign perf_fetched     = perf_fetched_q;
  assign perf_miss_cycles = perf_miss_cycles_q;
`else
  logic unused_fetch_load_s;
  assign unused_fetch_load_s = fetch_load_s;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined core. It owns the PC, issues addresses to the instruction cache, and rides out cache misses with a small state machine. It absorbs decode stalls and execute-stage redirects, then presents a registered instruction to the decode stage. The main decoder reads its opcode/funct slices and a per-instruction valid, and treats an invalid slot as a NOP.

## Interface
Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_1000, PC loaded at reset.
- NOP_INSTR, 32'h0000_0013, instruction word held in IF/ID when the slot is invalid.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- stall_d  in  1  decode stall from the hazard unit; holds the PC and IF/ID.
- redirect_valid  in  1  taken branch/jump resolved in execute.
- redirect_pc  in  XLEN  target address for the redirect.
- icache_req  out  1  fetch request.
- icache_addr  out  XLEN  fetch address; always equal to pc_f.
- icache_rdata  in  32  instruction word; valid only when icache_hit=1.
- icache_hit  in  1  same-cycle hit for icache_addr.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  XLEN  IF/ID PC.
- pcplus4_d  out  XLEN  IF/ID PC+4.
- valid_d  out  1  IF/ID slot holds a real instruction (decoder ihit).
- opcode_d  out  7  instr_d[6:0].
- funct_d  out  3  instr_d[14:12].

## Operation
- States: RUN, MISS, DRAIN.
- Reset (reset=0 at a rising edge):
  - pc_f=RESET_PC, state=RUN.
  - instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, valid_d=0.
  - icache_req=0 while reset=0.
- icache_req=1 in all states when reset=1. PC arithmetic wraps modulo 2^XLEN.
- Priority per cycle: redirect > stall_d > normal fetch.
- RUN:
  - Hit and no stall: IF/ID <= {icache_rdata, pc_f, pc_f+4, valid=1}; pc_f <= pc_f+4.
  - Miss and no stall: IF/ID valid_d <= 0, instr_d <= NOP_INSTR (bubble); state -> MISS.
  - stall_d=1: pc_f and IF/ID hold, hit or miss. The same fetch is re-issued next cycle.
- MISS:
  - pc_f is held.
  - On hit: same action as a RUN hit; state -> RUN.
  - Without a hit: bubble, unless stall_d=1, in which case IF/ID holds.
- Redirect in RUN:
  - pc_f <= {redirect_pc[XLEN-1:2],2'b00}.
  - IF/ID flushed: valid_d=0, instr_d=NOP_INSTR.
  - Overrides stall_d. State stays RUN.
- Redirect in MISS:
  - The outstanding refill must complete. The target (low bits cleared) is latched in pend_pc; state -> DRAIN; IF/ID flushed.
- DRAIN:
  - Bubbles are issued while pc_f is held on the old address.
  - On hit: the returned word is discarded; pc_f <= pend_pc; state -> RUN.
  - A new redirect in DRAIN overwrites pend_pc. Last writer wins.
- The outputs opcode_d and funct_d are pure slices of instr_d.

## Timing
- Hit to decode: an instruction hit at edge N is in IF/ID after edge N; valid_d=1 from cycle N+1.
- Sustained throughput: 1 instruction/cycle with back-to-back hits and no stalls.
- Redirect in RUN at edge N:
  - icache_addr equals the target in cycle N+1.
  - The first target instruction is in decode at N+2 at the earliest.
- Miss penalty equals the icache miss latency. No extra cycle on the RUN<->MISS transition.
- Redirect during MISS costs the remaining refill time plus 1 cycle.
- The cycle after reset deasserts, icache_addr=RESET_PC and icache_req=1.
- Reset mid-miss or mid-drain: state returns to RUN and pend_pc is ignored. The icache is responsible for aborting its own refill.

## Configuration
- FETCH_PERF_EN:
  - Defined: adds outputs perf_fetched[31:0] and perf_miss_cycles[31:0], both reset to 0.
  - perf_fetched increments on each IF/ID load with valid=1.
  - perf_miss_cycles increments on each cycle in MISS or DRAIN.
  - Both counters wrap at 2^32.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset with 4 consecutive hits -> pc_d sequence 0x1000, 0x1004, 0x1008, 0x100C; valid_d=1 from the 2nd cycle after the first fetch.
- Miss at 0x1008 for 3 cycles -> 3 bubbles (valid_d=0, instr_d=0x00000013), then pc_d=0x1008 once; state returns to RUN.
- stall_d=1 for 2 cycles with instr_d=0x00A00093 -> IF/ID and icache_addr unchanged; fetch resumes at the next PC.
- Redirect to 0x2002 during a stall -> flush wins; icache_addr=0x2000 next cycle; first valid pc_d=0x2000.
- Redirect to 0x3000 during a miss at 0x1010 -> DRAIN; word returned for 0x1010 discarded; next icache_addr=0x3000.
- Reset asserted mid-MISS -> valid_d=0, pc_f=0x1000, state RUN; with FETCH_PERF_EN defined, both counters read 0.
